nchu_lif_array: RTL

- Parametrised, multi-channel successor to the single-neuron NCHU integrate-and-fire unit.
- Holds N_CH membrane potentials and accumulates signed MAC results per channel.
- On each timestep tick it sweeps all channels once, applying leak, threshold, fire and refractory handling.
- Emits one spike vector per timestep to the downstream spike router.

---
 rtl/nchu_pkg.sv | 29 ++
 rtl/nchu_lif_update.sv | 42 ++++
 rtl/nchu_lif_array.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nchu_pkg.sv
// Shared types and helpers for the multi-channel NCHU leaky integrate-and-fire array.
package nchu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDone
    } state_e;

    // Channel index width; a single-channel array still gets a 1-bit select.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [31:0] sat_mem(input logic signed [31:0] x,
                                                   input int unsigned        w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/nchu_lif_update.sv
// Combinational leak/threshold/fire/refractory update for one channel; shared by all channels.
module nchu_lif_update
    import nchu_pkg::*;
#(
    parameter int unsigned MEM_W      = 12,
    parameter int unsigned REF_W      = 4,
    parameter int unsigned RESET_MODE = 0
) (
    input  logic signed [MEM_W-1:0] v_i,
    input  logic        [REF_W-1:0] refr_i,
    input  logic signed [MEM_W-1:0] threshold_i,
    input  logic        [2:0]       leak_shift_i,
    input  logic        [REF_W-1:0] refract_len_i,
    output logic signed [MEM_W-1:0] v_o,
    output logic        [REF_W-1:0] refr_o,
    output logic                    spike_o
);

    logic signed [31:0] v_ext;
    logic signed [31:0] thr_ext;
    logic signed [31:0] lk_ext;

    always_comb begin
        v_ext   = 32'(v_i);
        thr_ext = 32'(threshold_i);
        lk_ext  = (leak_shift_i == 3'd0) ? v_ext
                                         : sat_mem(v_ext - (v_ext >>> leak_shift_i), MEM_W);
        v_o     = '0;
        refr_o  = refr_i;
        spike_o = 1'b0;
        if (refr_i != '0) begin
            refr_o = refr_i - REF_W'(1);
        end else if (lk_ext >= thr_ext) begin
            spike_o = 1'b1;
            refr_o  = refract_len_i;
            v_o     = (RESET_MODE != 0) ? MEM_W'(sat_mem(lk_ext - thr_ext, MEM_W)) : '0;
        end else begin
            v_o = MEM_W'(lk_ext);
        end
    end

endmodule

// File: rtl/nchu_lif_array.sv
// N_CH-channel integrate-and-fire array: accumulates MAC input while idle, sweeps on each tick.
module nchu_lif_array
    import nchu_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned IN_W       = 8,
    parameter int unsigned MEM_W      = 12,
    parameter int unsigned REF_W      = 4,
    parameter int unsigned RESET_MODE = 0,
    localparam int unsigned CH_W      = ch_idx_w(N_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pulse_i,
    input  logic signed [IN_W-1:0]  mac_out_i,
    input  logic        [CH_W-1:0]  mac_ch_i,
    input  logic                    mac_valid_i,
    output logic                    in_ready_o,
    input  logic signed [MEM_W-1:0] threshold_i,
    input  logic        [2:0]       leak_shift_i,
    input  logic        [REF_W-1:0] refract_len_i,
    output logic        [N_CH-1:0]  spk_out_o,
    output logic                    spk_valid_o,
    output logic                    tick_overrun_o
);

    state_e                  state_q;
    logic        [CH_W-1:0]  idx_q;
    logic                    pulse_q;
    logic signed [MEM_W-1:0] v_q    [N_CH];
    logic        [REF_W-1:0] refr_q [N_CH];
    logic        [N_CH-1:0]  shadow_q, shadow_d;
    logic        [N_CH-1:0]  spk_out_q;
    logic                    spk_valid_q;
    logic                    overrun_q;
    logic signed [MEM_W-1:0] thr_q;
    logic        [2:0]       leak_q;
    logic        [REF_W-1:0] rlen_q;

    logic                    tick;
    logic                    acc_en;
    logic signed [MEM_W-1:0] acc_v;
    logic                    last_ch;
    logic signed [MEM_W-1:0] upd_v;
    logic        [REF_W-1:0] upd_refr;
    logic                    upd_spike;

    assign tick           = pulse_i & ~pulse_q;
    assign in_ready_o     = (state_q == StIdle);
    assign spk_out_o      = spk_out_q;
    assign spk_valid_o    = spk_valid_q;
    assign tick_overrun_o = overrun_q;
    assign last_ch        = (32'(idx_q) == N_CH - 1);

    // Inputs to refractory or nonexistent channels are dropped without back-pressure.
    always_comb begin
        acc_en = 1'b0;
        acc_v  = '0;
        if (32'(mac_ch_i) < N_CH) begin
            acc_en = mac_valid_i && (refr_q[mac_ch_i] == '0);
            acc_v  = MEM_W'(sat_mem(32'(v_q[mac_ch_i]) + 32'(mac_out_i), MEM_W));
        end
    end

    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = upd_spike;
    end

    nchu_lif_update #(
        .MEM_W      (MEM_W),
        .REF_W      (REF_W),
        .RESET_MODE (RESET_MODE)
    ) u_update (
        .v_i           (v_q[idx_q]),
        .refr_i        (refr_q[idx_q]),
        .threshold_i   (thr_q),
        .leak_shift_i  (leak_q),
        .refract_len_i (rlen_q),
        .v_o           (upd_v),
        .refr_o        (upd_refr),
        .spike_o       (upd_spike)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pulse_q     <= 1'b0;
            shadow_q    <= '0;
            spk_out_q   <= '0;
            spk_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            thr_q       <= '0;
            leak_q      <= '0;
            rlen_q      <= '0;
            for (int c = 0; c < N_CH; c++) begin
                v_q[c]    <= '0;
                refr_q[c] <= '0;
            end
        end else begin
            pulse_q     <= pulse_i;
            spk_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (acc_en) begin
                        v_q[mac_ch_i] <= acc_v;
                    end
                    if (tick) begin
                        thr_q    <= threshold_i;
                        leak_q   <= leak_shift_i;
                        rlen_q   <= refract_len_i;
                        idx_q    <= '0;
                        shadow_q <= '0;
                        state_q  <= StSweep;
                    end
                end
                StSweep: begin
                    if (tick) begin
                        overrun_q <= 1'b1;
                    end
                    v_q[idx_q]    <= upd_v;
                    refr_q[idx_q] <= upd_refr;
                    shadow_q      <= shadow_d;
                    if (last_ch) begin
                        spk_out_q   <= shadow_d;
                        spk_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + CH_W'(1);
                    end
                end
                StDone: begin
                    if (tick) begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
